// File: rtl/pc_sequencer.sv
// pc_sequencer: registered next-PC unit with branch/jump/call offsets, flush redirect
// and a circular return-address stack that overwrites its oldest entry when full.
module pc_sequencer #(
    parameter int ADDR_WIDTH    = 16,
    parameter int BR_OFF_WIDTH  = 8,
    parameter int JMP_OFF_WIDTH = 12,
    parameter int RAS_DEPTH     = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
    parameter int PC_INC        = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          stall,
    input  logic                          flush,
    input  logic [ADDR_WIDTH-1:0]         flush_addr,
    input  logic                          br_taken,
    input  logic [BR_OFF_WIDTH-1:0]       br_off,
    input  logic                          jump,
    input  logic                          call,
    input  logic [JMP_OFF_WIDTH-1:0]      jmp_off,
    input  logic                          ret,
    output logic [ADDR_WIDTH-1:0]         pc,
    output logic [$clog2(RAS_DEPTH):0]    ras_count,
    output logic                          ras_ovf,
    output logic                          ras_unf
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] stack [RAS_DEPTH];
    logic [PW-1:0]         top, top_nxt;
    logic [ADDR_WIDTH-1:0] br_ext, jmp_ext, inc_pc, pc_nxt;
    logic [CW-1:0]         count_nxt;
    logic                  active, empty, full, push, pop, unf;

    assign br_ext  = {{(ADDR_WIDTH-BR_OFF_WIDTH){br_off[BR_OFF_WIDTH-1]}}, br_off};
    assign jmp_ext = {{(ADDR_WIDTH-JMP_OFF_WIDTH){jmp_off[JMP_OFF_WIDTH-1]}}, jmp_off};
    assign inc_pc  = pc + ADDR_WIDTH'(PC_INC);
    assign active  = !flush && !stall;
    assign empty   = ras_count == '0;
    assign full    = ras_count == CW'(RAS_DEPTH);
    assign push    = active && call;
    // ret only acts when no higher-priority redirect is present
    assign pop     = active && !call && !jump && !br_taken && ret && !empty;
    assign unf     = active && !call && !jump && !br_taken && ret && empty;

    always_comb begin
        pc_nxt    = flush ? flush_addr :
                    stall ? pc :
                    (call || jump) ? pc + jmp_ext :
                    br_taken ? pc + br_ext :
                    pop ? stack[top] : inc_pc;
        count_nxt = push ? (full ? ras_count : ras_count + 1'b1) :
                    pop ? ras_count - 1'b1 : ras_count;
        top_nxt   = push ? top + 1'b1 : pop ? top - 1'b1 : top;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_ADDR;
            ras_count <= '0;
            top       <= '0;
            ras_ovf   <= 1'b0;
            ras_unf   <= 1'b0;
        end else begin
            pc        <= pc_nxt;
            ras_count <= count_nxt;
            top       <= top_nxt;
            ras_ovf   <= push && full;
            ras_unf   <= unf;
        end
    end

    // When full, top+1 lands on the oldest slot, so the push overwrites it.
    always_ff @(posedge clk) begin
        if (push) stack[top + 1'b1] <= inc_pc;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised next-PC unit: the registered successor to the combinational branch adder. It holds the program counter and each cycle selects the next PC from one of these sources:
- sequential increment
- short sign-extended branch offset
- long sign-extended jump offset
- return-address stack pop (call/return)
- external flush address

It sits between the fetch stage and the decode/branch-resolution logic. Stall and flush come from the hazard unit.

Parameters:
ADDR_WIDTH, 16, width of PC and all addresses
BR_OFF_WIDTH, 8, branch offset width, two's complement
JMP_OFF_WIDTH, 12, jump/call offset width, two's complement
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)
RESET_ADDR, 0, PC value on reset
PC_INC, 1, sequential increment

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold PC and stack this cycle
flush  in  1  redirect PC to flush_addr
flush_addr  in  ADDR_WIDTH  flush target
br_taken  in  1  take branch
br_off  in  BR_OFF_WIDTH  signed branch offset, relative to current pc
jump  in  1  unconditional relative jump
call  in  1  jump that also pushes return address
jmp_off  in  JMP_OFF_WIDTH  signed jump/call offset, relative to current pc
ret  in  1  pop stack into PC
pc  out  ADDR_WIDTH  current program counter (registered)
ras_count  out  clog2(RAS_DEPTH)+1  valid stack entries
ras_ovf  out  1  one-cycle pulse: call overwrote oldest entry
ras_unf  out  1  one-cycle pulse: ret with empty stack

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-operation):
  - pc=RESET_ADDR, ras_count=0, ras_ovf=0, ras_unf=0.
  - Stack contents are don't-care.
  - First update occurs at the first rising edge after rst_n deasserts.
- All outputs are registered. A control input sampled at edge N is reflected on pc after edge N (1-cycle latency).
- Next-PC priority per edge, highest first:
  1. flush: pc<=flush_addr. Stack and ras_count unchanged. Flush overrides stall.
  2. stall: pc, stack and ras_count all hold; every other input is ignored.
  3. call: pc<=pc+sext(jmp_off); push pc+PC_INC.
  4. jump: pc<=pc+sext(jmp_off).
  5. br_taken: pc<=pc+sext(br_off).
  6. ret: if ras_count>0, pc<=top and pop; else pc<=pc+PC_INC and ras_unf=1.
  7. otherwise: pc<=pc+PC_INC.
- Simultaneous requests: the lower-priority request is dropped; there is no queuing. Cases:
  - call+jump acts as call.
  - call+ret: call wins, no pop.
  - jump+br_taken: jump wins.
- Arithmetic:
  - Offsets are sign-extended to ADDR_WIDTH.
  - All sums are modulo 2^ADDR_WIDTH; no overflow flag; wrap-around is legal.
- Stack structure: circular buffer with a top pointer.
- Push when ras_count<RAS_DEPTH: ras_count increments.
- Push when full:
  - Writes over the oldest entry; ras_count stays RAS_DEPTH.
  - ras_ovf pulses for one cycle.
  - The new entry becomes top; subsequent pops return the newest RAS_DEPTH addresses in LIFO order.
- ras_ovf and ras_unf are high only for the cycle after the causing edge. They are never asserted on stall or flush cycles.

Test Plan:
- Reset then idle (defaults): rst_n low then high, no controls for 3 edges -> pc=0x0000,0x0001,0x0002,0x0003; ras_count=0.
- Branch sign: pc=0x0010, br_taken, br_off=0xFE -> pc=0x000E; next br_off=0x7F -> pc=0x008D.
- Jump wrap: pc=0xFFF0, jump, jmp_off=0x020 -> pc=0x0010; jump+br_taken together -> jump target used.
- Call/return: pc=0x0100, call, jmp_off=0x050 -> pc=0x0150, ras_count=1. Then ret -> pc=0x0101, ras_count=0.
- Overflow/underflow (RAS_DEPTH=4):
  - 5 consecutive calls -> ras_ovf pulses once (after the 5th call), ras_count=4.
  - 4 rets -> the 5th, 4th, 3rd, 2nd return addresses in that order.
  - 5th ret -> pc+1, ras_unf pulses one cycle.
- Stall/flush/reset:
  - call with stall -> pc and ras_count unchanged.
  - flush with stall, flush_addr=0x4000 -> pc=0x4000, stack unchanged.
  - rst_n low mid-sequence -> pc=0x0000 immediately (before next edge), ras_count=0.
